// File: rtl/clock_set_controller_if.sv
// -----------------------------------------------------------------------------
// clock_set_controller_if
// Bundles the user inputs and the step strobes of the clock set controller.
//   Inputs to controller : i_tick (1 Hz pulse), i_btn_mode/i_btn_up/i_btn_down
//                          (debounced levels), i_sec_carryup/i_min_carryup
//                          (same-cycle carry flags from the time counters)
//   Outputs of controller: o_{sec,min,hour}_{up,down} step strobes,
//                          o_mode (0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC),
//                          o_blink (blink enable for the field being set)
// slave  : view used by the controller
// master : view used by whatever drives the buttons and consumes the strobes
// -----------------------------------------------------------------------------
interface clock_set_controller_if;
  logic       i_tick;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
  logic       i_sec_carryup;
  logic       i_min_carryup;
  logic       o_sec_up;
  logic       o_sec_down;
  logic       o_min_up;
  logic       o_min_down;
  logic       o_hour_up;
  logic       o_hour_down;
  logic [1:0] o_mode;
  logic       o_blink;

  modport slave (
    input  i_tick, i_btn_mode, i_btn_up, i_btn_down, i_sec_carryup, i_min_carryup,
    output o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down,
    output o_mode, o_blink
  );

  modport master (
    output i_tick, i_btn_mode, i_btn_up, i_btn_down, i_sec_carryup, i_min_carryup,
    input  o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down,
    input  o_mode, o_blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
// Mode FSM and step-strobe generator for a digital clock.
//   RUN      : seconds step on i_tick, carries chain combinationally into
//              minutes and hours.
//   SET_*    : time frozen; up/down button edges step only the selected field.
// Ports:
//   i_clk  - clock, rising edge
//   i_rstn - asynchronous active-low reset
//   bus    - clock_set_controller_if.slave (buttons, tick, carries, strobes,
//            o_mode, o_blink)
// Parameters: CNT_W (repeat counter width), HOLD_DLY (hold cycles before first
//   repeat), REPEAT_PER (cycles between repeats; expected <= HOLD_DLY).
// Optional feature: define AUTO_REPEAT_EN to build the hold-to-repeat counter.
// -----------------------------------------------------------------------------
module clock_set_controller #(
  parameter int CNT_W      = 26,
  parameter int HOLD_DLY   = 25000000,
  parameter int REPEAT_PER = 5000000
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  clock_set_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       blink_q, blink_d;
  logic [2:0] btn_q, btn_d;   // previous samples {mode, up, down}
  logic [2:0] arm_q, arm_d;   // set once a button has been seen low after reset
  logic [2:0] btn_s;
  logic [2:0] rise_s;
  logic       mode_rise_s, up_rise_s, dn_rise_s;
  logic       rpt_s;
  logic       up_evt_s, dn_evt_s;
  logic [5:0] strb_s;         // {hour_up, hour_down, min_up, min_down, sec_up, sec_down}

  assign btn_s       = {bus.i_btn_mode, bus.i_btn_up, bus.i_btn_down};
  // A button held through reset stays disarmed until sampled low, so it cannot
  // fake an edge against the cleared history.
  assign rise_s      = btn_s & ~btn_q & arm_q;
  assign mode_rise_s = rise_s[2];
  assign up_rise_s   = rise_s[1];
  assign dn_rise_s   = rise_s[0];

  // Mode changes win over up/down; a press with the other button high is void.
  assign up_evt_s = ~mode_rise_s & ~bus.i_btn_down & (up_rise_s | (rpt_s & bus.i_btn_up));
  assign dn_evt_s = ~mode_rise_s & ~bus.i_btn_up   & (dn_rise_s | (rpt_s & bus.i_btn_down));

  // Button history and arming
  always_comb begin
    btn_d = btn_s;
    arm_d = arm_q | ~btn_s;
  end

  // Next mode and blink state
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    if (mode_rise_s) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
      blink_d = (state_d != RUN);
    end else if (state_q == RUN) begin
      blink_d = 1'b0;
    end else if (bus.i_tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold counter: counts while exactly one of up/down is held in a SET state.
  // On reaching HOLD_DLY it fires and reloads so the next hit is REPEAT_PER later.
  always_comb begin
    cnt_d = cnt_q;
    rpt_s = 1'b0;
    if (mode_rise_s || (state_q == RUN) || !(bus.i_btn_up ^ bus.i_btn_down)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(HOLD_DLY)) begin
      rpt_s = 1'b1;
      cnt_d = CNT_W'(HOLD_DLY - REPEAT_PER + 1);
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{CNT_W, HOLD_DLY, REPEAT_PER};
  assign rpt_s        = 1'b0;
`endif

  // Step strobes: zero-latency, forced low while reset is asserted
  always_comb begin
    strb_s = 6'b000000;
    if (i_rstn) begin
      case (state_q)
        RUN: begin
          strb_s[1] = bus.i_tick;
          strb_s[3] = bus.i_sec_carryup & strb_s[1];
          strb_s[5] = bus.i_min_carryup & strb_s[3];
        end
        SET_HOUR: begin
          strb_s[5] = up_evt_s;
          strb_s[4] = dn_evt_s;
        end
        SET_MIN: begin
          strb_s[3] = up_evt_s;
          strb_s[2] = dn_evt_s;
        end
        SET_SEC: begin
          strb_s[1] = up_evt_s;
          strb_s[0] = dn_evt_s;
        end
        default: strb_s = 6'b000000;
      endcase
    end else begin
      strb_s = 6'b000000;
    end
  end

  // State, blink and button history registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RUN;
      blink_q <= 1'b0;
      btn_q   <= 3'b000;
      arm_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      btn_q   <= btn_d;
      arm_q   <= arm_d;
    end
  end

  assign bus.o_hour_up   = strb_s[5];
  assign bus.o_hour_down = strb_s[4];
  assign bus.o_min_up    = strb_s[3];
  assign bus.o_min_down  = strb_s[2];
  assign bus.o_sec_up    = strb_s[1];
  assign bus.o_sec_down  = strb_s[0];
  assign bus.o_mode      = state_q;
  assign bus.o_blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
// Directed bench for clock_set_controller. Strobe vector ordering used below:
// {hour_up, hour_down, min_up, min_down, sec_up, sec_down}.
// Repeat timing assumes HOLD_DLY=10, REPEAT_PER=4 when AUTO_REPEAT_EN is set.
// -----------------------------------------------------------------------------
module tb_clock_set_controller;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  localparam logic [5:0] NONE    = 6'b000000;
  localparam logic [5:0] HOUR_UP = 6'b100000;
  localparam logic [5:0] MIN_UP  = 6'b001000;
  localparam logic [5:0] MIN_DN  = 6'b000100;
  localparam logic [5:0] SEC_UP  = 6'b000010;
  localparam logic [5:0] CHAIN2  = 6'b001010;
  localparam logic [5:0] CHAIN3  = 6'b101010;

  clock_set_controller_if bus ();

  clock_set_controller #(
    .CNT_W      (8),
    .HOLD_DLY   (10),
    .REPEAT_PER (4)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  logic [5:0] strb;
  assign strb = {bus.o_hour_up, bus.o_hour_down, bus.o_min_up,
                 bus.o_min_down, bus.o_sec_up, bus.o_sec_down};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    bus.i_btn_mode = 1'b1;
    clk1();
    bus.i_btn_mode = 1'b0;
    clk1();
  endtask

  function automatic logic [5:0] rpt_exp(input int k, input logic [5:0] hit);
`ifdef AUTO_REPEAT_EN
    return ((k == 0) || (k >= 10 && ((k - 10) % 4) == 0)) ? hit : NONE;
`else
    return (k == 0) ? hit : NONE;
`endif
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.i_tick = 1'b1;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up = 1'b0;
    bus.i_btn_down = 1'b0;
    bus.i_sec_carryup = 1'b0;
    bus.i_min_carryup = 1'b0;

    // Reset state, strobes gated even with a tick present
    @(posedge clk);
    #2;
    chk("rst_strobes", strb, NONE);
    chk("rst_mode", {4'b0, bus.o_mode}, 6'd0);
    chk("rst_blink", {5'b0, bus.o_blink}, 6'd0);
    clk1();
    rstn = 1'b1;
    bus.i_tick = 1'b0;
    clk1();

    // RUN chaining
    bus.i_tick = 1'b1;
    #1 chk("run_tick", strb, SEC_UP);
    bus.i_sec_carryup = 1'b1;
    #1 chk("run_sec_carry", strb, CHAIN2);
    bus.i_min_carryup = 1'b1;
    #1 chk("run_59_59", strb, CHAIN3);
    bus.i_tick = 1'b0;
    #1 chk("run_no_tick", strb, NONE);
    clk1();
    bus.i_sec_carryup = 1'b0;
    bus.i_min_carryup = 1'b0;

    // Three mode presses, tick frozen, blink entry and toggle
    for (int i = 1; i <= 3; i++) begin
      bus.i_btn_mode = 1'b1;
      #1 chk("mode_edge_strobes", strb, NONE);
      clk1();
      chk("mode_step", {4'b0, bus.o_mode}, 6'(i));
      chk("blink_entry", {5'b0, bus.o_blink}, 6'd1);
      bus.i_btn_mode = 1'b0;
      bus.i_tick = 1'b1;
      bus.i_sec_carryup = 1'b1;
      bus.i_min_carryup = 1'b1;
      #1 chk("set_tick_frozen", strb, NONE);
      clk1();
      chk("blink_toggle", {5'b0, bus.o_blink}, 6'd0);
      bus.i_tick = 1'b0;
      bus.i_sec_carryup = 1'b0;
      bus.i_min_carryup = 1'b0;
    end
    press_mode();
    chk("mode_wrap", {4'b0, bus.o_mode}, 6'd0);
    chk("blink_run", {5'b0, bus.o_blink}, 6'd0);

    // SET_MIN up then down
    press_mode();
    press_mode();
    chk("mode_set_min", {4'b0, bus.o_mode}, 6'd2);
    bus.i_btn_up = 1'b1;
    #1 chk("min_up", strb, MIN_UP);
    clk1();
    chk("min_up_held", strb, NONE);
    bus.i_btn_up = 1'b0;
    clk1();
    bus.i_btn_down = 1'b1;
    #1 chk("min_down", strb, MIN_DN);
    clk1();
    chk("min_down_held", strb, NONE);
    bus.i_btn_down = 1'b0;
    clk1();

    // Up and down together, then mode with up
    bus.i_btn_up = 1'b1;
    bus.i_btn_down = 1'b1;
    #1 chk("both_rise", strb, NONE);
    clk1();
    bus.i_btn_up = 1'b0;
    bus.i_btn_down = 1'b0;
    clk1();
    bus.i_btn_mode = 1'b1;
    bus.i_btn_up = 1'b1;
    #1 chk("mode_beats_up", strb, NONE);
    clk1();
    chk("mode_beats_up_state", {4'b0, bus.o_mode}, 6'd3);
    bus.i_btn_mode = 1'b0;
    #1 chk("up_held_after_mode", strb, NONE);
    clk1();
    bus.i_btn_up = 1'b0;
    clk1();

    // Hold up 30 cycles in SET_HOUR
    press_mode();
    press_mode();
    chk("mode_set_hour", {4'b0, bus.o_mode}, 6'd1);
    bus.i_btn_up = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #1 chk($sformatf("hour_hold_c%0d", k), strb, rpt_exp(k, HOUR_UP));
      clk1();
    end
    bus.i_btn_up = 1'b0;
    clk1();

    // SET_SEC hold, reset mid-sequence with mode and up held through it
    press_mode();
    press_mode();
    chk("mode_set_sec", {4'b0, bus.o_mode}, 6'd3);
    bus.i_btn_up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1 chk($sformatf("sec_hold_c%0d", k), strb, rpt_exp(k, SEC_UP));
      clk1();
    end
    #2;
    bus.i_btn_mode = 1'b1;
    bus.i_tick = 1'b1;
    rstn = 1'b0;
    #1 chk("mid_rst_strobes", strb, NONE);
    chk("mid_rst_mode", {4'b0, bus.o_mode}, 6'd0);
    chk("mid_rst_blink", {5'b0, bus.o_blink}, 6'd0);
    clk1();
    clk1();
    rstn = 1'b1;
    bus.i_tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk1();
      chk("post_rst_strobes", strb, NONE);
      chk("post_rst_mode", {4'b0, bus.o_mode}, 6'd0);
    end
    bus.i_btn_mode = 1'b0;
    clk1();
    bus.i_btn_mode = 1'b1;
    clk1();
    chk("post_rst_mode_armed", {4'b0, bus.o_mode}, 6'd1);
    bus.i_btn_mode = 1'b0;
    #1 chk("post_rst_up_no_edge", strb, NONE);
    clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 26, setting the width of the auto-repeat counter.
REQ-002 The block SHALL have parameter HOLD_DLY, default 25000000, giving the cycles a button is held before the first repeat.
REQ-003 The block SHALL have parameter REPEAT_PER, default 5000000, giving the cycles between repeats.
REQ-004 i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_tick  input  1  one-cycle 1 Hz timebase pulse.
REQ-007 i_btn_mode, i_btn_up, i_btn_down  input  1 each  debounced button levels, active-high.
REQ-008 i_sec_carryup, i_min_carryup  input  1 each  same-cycle carry flags from the seconds and minutes counters.
REQ-009 o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down  output  1 each  step strobes to the three counters.
REQ-010 o_mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
REQ-011 o_blink  output  1  display blink enable for the field being set.

Function
REQ-012 The FSM SHALL cycle RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, advancing one state per i_btn_mode rising edge; rising edge = current sample 1, previous registered sample 0.
REQ-013 In RUN: o_sec_up = i_tick; o_min_up = i_sec_carryup & o_sec_up; o_hour_up = i_min_carryup & o_min_up; all down strobes = 0. Chaining is combinational, zero latency.
REQ-014 In SET states, i_tick SHALL NOT drive any counter (time frozen), and carries SHALL NOT propagate between fields.
REQ-015 In a SET state, an up event SHALL assert only the up strobe of the selected field (hour/min/sec) for exactly one cycle; a down event likewise asserts the down strobe.
REQ-016 An up event SHALL occur in the cycle of an i_btn_up rising edge while i_btn_down is 0; down is symmetric.
REQ-017 Both up and down high in the same cycle SHALL produce no strobe and SHALL clear the repeat counter; up and down strobes SHALL never be asserted together.
REQ-018 A mode rising edge in the same cycle as an up/down edge SHALL take priority: the state advances and no strobe is issued that cycle.
REQ-019 o_blink SHALL be 0 in RUN, SHALL toggle on each i_tick in SET states, and SHALL be forced to 1 on entry to each SET state.
REQ-020 The CNT_W-bit repeat counter SHALL clear on every mode change and whenever neither button or both buttons are held, and SHALL saturate rather than wrap.

Reset
REQ-021 Asserting i_rstn low SHALL immediately set state RUN, o_mode 0, o_blink 0, repeat counter 0, and button history 0, including in the middle of a hold or repeat sequence.
REQ-022 During reset all strobes SHALL be 0. After release, a button already high SHALL NOT create an edge until it has been sampled low.

Configuration
REQ-023 With AUTO_REPEAT_EN defined, a single button held in a SET state SHALL issue an extra event when the hold count reaches HOLD_DLY, then one every REPEAT_PER cycles until release.
REQ-024 Without AUTO_REPEAT_EN, the repeat counter SHALL not be built and a held button SHALL produce exactly one event per rising edge.

Verification
REQ-025 RUN, seconds counter at 59, minutes counter at 59, i_tick pulse -> o_sec_up, o_min_up, and o_hour_up all high in that same cycle.
REQ-026 Three mode presses -> o_mode 1, 2, 3, and i_tick during these states gives no strobes; a fourth press -> o_mode 0.
REQ-027 SET_MIN, up press then down press -> one o_min_up pulse then one o_min_down pulse; o_hour_* and o_sec_* remain 0.
REQ-028 AUTO_REPEAT_EN, HOLD_DLY=10, REPEAT_PER=4, up held 30 cycles in SET_HOUR -> o_hour_up at cycles 0, 10, 14, 18, 22, 26.
REQ-029 Up and down rising in the same cycle -> no strobe; mode and up rising together -> state advances, no strobe.
REQ-030 Reset asserted mid-repeat in SET_SEC -> o_mode 0, all outputs 0; with up still held after release -> no o_sec_up.
